// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Merges hazard, branch, cache-miss and halt requests into per-stage
// write-enable / flush / bubble controls and arbitrates the single
// main-memory fill port between the instruction and data caches.
module pipeline_stall_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard_stall,
   input  logic             branch_taken_ID,
   input  logic             icache_miss,
   input  logic             dcache_miss,
   input  logic             mem_ready,
   input  logic             halt_WB,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             idex_we,
   output logic             exmem_we,
   output logic             memwb_bubble,
   output logic             mem_req_d,
   output logic             mem_req_i,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DFILL = 2'd1,
      IFILL = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           stateReg;
   state_t           stateNext;
   logic [CNT_W-1:0] stallCntReg;
   logic             countThisCycle;

   // State register; reset always returns to RUN, aborting any fill or halt.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg <= RUN;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Mealy outputs and next state. Everything defaults to "frozen, no
   // request" so reset and HALT need no explicit assignments.
   always_comb begin
      stateNext    = stateReg;
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b0;
      mem_req_d    = 1'b0;
      mem_req_i    = 1'b0;

      if (rst) begin
         stateNext = RUN;
      end else begin
         unique case (stateReg)
            RUN: begin
               if (halt_WB) begin
                  // HLT reached WB: freeze everything from now on.
                  stateNext = HALT;
               end else if (dcache_miss) begin
                  // Data miss wins over an instruction miss; the fill
                  // request itself starts next cycle in DFILL.
                  memwb_bubble = 1'b1;
                  stateNext    = DFILL;
               end else if (hazard_stall) begin
                  // Hold IF and ID, push a bubble into EX. A taken branch
                  // seen now is dropped; it resolves again next cycle.
                  idex_bubble = 1'b1;
                  idex_we     = 1'b1;
                  exmem_we    = 1'b1;
               end else if (icache_miss) begin
                  // No valid instruction this cycle: feed a NOP into ID
                  // while the back end keeps draining.
                  ifid_we    = 1'b1;
                  ifid_flush = 1'b1;
                  idex_we    = 1'b1;
                  exmem_we   = 1'b1;
                  stateNext  = IFILL;
               end else if (branch_taken_ID) begin
                  // Squash the wrong-path instruction already fetched.
                  pc_we      = 1'b1;
                  ifid_we    = 1'b1;
                  ifid_flush = 1'b1;
                  idex_we    = 1'b1;
                  exmem_we   = 1'b1;
               end else begin
                  pc_we    = 1'b1;
                  ifid_we  = 1'b1;
                  idex_we  = 1'b1;
                  exmem_we = 1'b1;
               end
            end

            DFILL: begin
               // Whole pipe frozen, MEM/WB fed NOPs until the data returns.
               memwb_bubble = 1'b1;
               mem_req_d    = 1'b1;
               if (mem_ready) begin
                  stateNext = icache_miss ? IFILL : RUN;
               end
            end

            IFILL: begin
               mem_req_i = 1'b1;
               if (dcache_miss) begin
                  // A data miss during the I-fill only freezes the back
                  // end; its own fill waits until the port is free.
                  memwb_bubble = 1'b1;
               end else begin
                  ifid_we    = 1'b1;
                  ifid_flush = 1'b1;
                  idex_we    = 1'b1;
                  exmem_we   = 1'b1;
               end
               if (mem_ready) begin
                  stateNext = dcache_miss ? DFILL : RUN;
               end
            end

            HALT: begin
               stateNext = HALT;
            end

            default: begin
               stateNext = RUN;
            end
         endcase
      end
   end

   assign halted = (stateReg == HALT);

   assign countThisCycle = !rst && !pc_we && (stateReg != HALT);

   // Saturating count of cycles in which the PC did not advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         stallCntReg <= '0;
      end else if (countThisCycle && (stallCntReg != CNT_MAX)) begin
         stallCntReg <= stallCntReg + CNT_ONE;
      end
   end

   assign stall_cycles = stallCntReg;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl: directed vectors, a rule-level model
// checked on every cycle, and literal expectations at key points.
module tb_pipeline_stall_ctrl;

   localparam int CW = 4;

   // Input vector bits: {hazard, branch, imiss, dmiss, memReady, halt}
   localparam logic [5:0] HZ = 6'b100000;
   localparam logic [5:0] BR = 6'b010000;
   localparam logic [5:0] IM = 6'b001000;
   localparam logic [5:0] DM = 6'b000100;
   localparam logic [5:0] MR = 6'b000010;
   localparam logic [5:0] HW = 6'b000001;

   // Output vector bits:
   // {pc,ifid,flush,idexBub,idex,exmem,memwbBub,reqD,reqI,halted}
   localparam logic [9:0] O_FREEZE  = 10'b0000001000;
   localparam logic [9:0] O_LOADUSE = 10'b0001110000;
   localparam logic [9:0] O_IFETCH  = 10'b0110110000;
   localparam logic [9:0] O_BRANCH  = 10'b1110110000;
   localparam logic [9:0] O_NORMAL  = 10'b1100110000;
   localparam logic [9:0] O_REQD    = 10'b0000000100;
   localparam logic [9:0] O_REQI    = 10'b0000000010;
   localparam int         CNT_MAX   = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          hazard_stall = 1'b0;
   logic          branch_taken_ID = 1'b0;
   logic          icache_miss = 1'b0;
   logic          dcache_miss = 1'b0;
   logic          mem_ready = 1'b0;
   logic          halt_WB = 1'b0;
   logic          pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we;
   logic          memwb_bubble, mem_req_d, mem_req_i, halted;
   logic [CW-1:0] stall_cycles;

   int checks = 0;
   int errors = 0;
   int cycleNo = 0;

   // Model: which fill is being served (0 none, 1 data, 2 instruction),
   // whether the pipe is halted, and the expected stall count.
   logic modelOn = 1'b0;
   int   mServe = 0;
   logic mHalted = 1'b0;
   int   mCnt = 0;

   pipeline_stall_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .hazard_stall(hazard_stall), .branch_taken_ID(branch_taken_ID),
      .icache_miss(icache_miss), .dcache_miss(dcache_miss),
      .mem_ready(mem_ready), .halt_WB(halt_WB),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .idex_we(idex_we), .exmem_we(exmem_we),
      .memwb_bubble(memwb_bubble), .mem_req_d(mem_req_d),
      .mem_req_i(mem_req_i), .halted(halted), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // Per-cycle comparison against the model, then advance the model.
   always @(negedge clk) begin : cmp
      logic [9:0] e;
      logic [9:0] a;
      if (modelOn) begin
         a = {pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we,
              memwb_bubble, mem_req_d, mem_req_i, halted};
         e = '0;
         if (rst)                  e[0] = mHalted;
         else if (mHalted)         e = 10'b0000000001;
         else if (mServe == 1)     e = O_FREEZE | O_REQD;
         else if (mServe == 2)     e = (dcache_miss ? O_FREEZE : O_IFETCH) | O_REQI;
         else if (halt_WB)         e = '0;
         else if (dcache_miss)     e = O_FREEZE;
         else if (hazard_stall)    e = O_LOADUSE;
         else if (icache_miss)     e = O_IFETCH;
         else if (branch_taken_ID) e = O_BRANCH;
         else                      e = O_NORMAL;

         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs cyc %0d: got %b, expected %b", cycleNo, a, e);
         end
         checks++;
         if (stall_cycles !== mCnt[CW-1:0]) begin
            errors++;
            $display("FAIL stall_cycles cyc %0d: got %0d, expected %0d",
                     cycleNo, stall_cycles, mCnt);
         end
         checks++;
         if ((mem_req_d & mem_req_i) !== 1'b0) begin
            errors++;
            $display("FAIL grant_excl cyc %0d: got d=%b i=%b, expected not both",
                     cycleNo, mem_req_d, mem_req_i);
         end

         if (rst) begin
            mServe  = 0;
            mHalted = 1'b0;
            mCnt    = 0;
         end else if (!mHalted) begin
            if (!e[9] && mCnt < CNT_MAX) mCnt++;
            case (mServe)
               1: if (mem_ready) mServe = icache_miss ? 2 : 0;
               2: if (mem_ready) mServe = dcache_miss ? 1 : 0;
               default: begin
                  if (halt_WB)                          mHalted = 1'b1;
                  else if (dcache_miss)                 mServe = 1;
                  else if (!hazard_stall && icache_miss) mServe = 2;
               end
            endcase
         end
      end
   end

   task automatic step(input logic r, input logic [5:0] v);
      @(posedge clk);
      #1;
      rst = r;
      {hazard_stall, branch_taken_ID, icache_miss, dcache_miss, mem_ready, halt_WB} = v;
      @(negedge clk);
      #1;
      cycleNo++;
      $display("cyc %0d rst=%b in=%b pc=%b ifid=%b fl=%b bub=%b/%b req=%b%b halted=%b cnt=%0d",
               cycleNo, r, v, pc_we, ifid_we, ifid_flush, idex_bubble, memwb_bubble,
               mem_req_d, mem_req_i, halted, stall_cycles);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   initial begin
      // Reset
      step(1'b1, 6'b0);
      modelOn = 1'b1;
      step(1'b1, 6'b0);
      chk("rst_pc_we", 32'(pc_we), 0);
      chk("rst_req_d", 32'(mem_req_d), 0);
      step(1'b0, 6'b0);
      chk("reset_cnt", 32'(stall_cycles), 0);
      chk("reset_halted", 32'(halted), 0);
      chk("run_pc_we", 32'(pc_we), 1);

      // Load-use with simultaneous branch
      step(1'b0, HZ | BR);
      chk("lu_pc_we", 32'(pc_we), 0);
      chk("lu_ifid_we", 32'(ifid_we), 0);
      chk("lu_idex_bubble", 32'(idex_bubble), 1);
      chk("lu_ifid_flush", 32'(ifid_flush), 0);
      step(1'b0, BR);
      chk("br_ifid_flush", 32'(ifid_flush), 1);
      chk("br_pc_we", 32'(pc_we), 1);
      chk("lu_cnt", 32'(stall_cycles), 1);
      step(1'b0, MR);
      chk("stray_ready_pc_we", 32'(pc_we), 1);

      // D miss, mem_ready at cycle 5
      step(1'b1, 6'b0);
      step(1'b0, DM);
      chk("dm0_memwb_bubble", 32'(memwb_bubble), 1);
      chk("dm0_exmem_we", 32'(exmem_we), 0);
      chk("dm0_req_d", 32'(mem_req_d), 0);
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, DM);
         chk("dfill_req_d", 32'(mem_req_d), 1);
      end
      step(1'b0, DM | MR);
      chk("dm5_req_d", 32'(mem_req_d), 1);
      chk("dm5_pc_we", 32'(pc_we), 0);
      step(1'b0, 6'b0);
      chk("dm6_pc_we", 32'(pc_we), 1);
      chk("dm6_req_d", 32'(mem_req_d), 0);
      chk("dm6_cnt", 32'(stall_cycles), 6);

      // Simultaneous I and D misses: D first
      step(1'b1, 6'b0);
      step(1'b0, IM | DM);
      chk("both_memwb_bubble", 32'(memwb_bubble), 1);
      chk("both_req_d", 32'(mem_req_d), 0);
      step(1'b0, IM | DM);
      chk("both_dfill_req_d", 32'(mem_req_d), 1);
      chk("both_dfill_req_i", 32'(mem_req_i), 0);
      step(1'b0, IM | DM | MR);
      step(1'b0, IM);
      chk("both_ifill_req_i", 32'(mem_req_i), 1);
      chk("both_ifill_req_d", 32'(mem_req_d), 0);
      chk("both_ifill_flush", 32'(ifid_flush), 1);
      step(1'b0, IM | MR);
      step(1'b0, 6'b0);
      chk("both_done_pc_we", 32'(pc_we), 1);

      // I miss, then D miss arrives during the I-fill
      step(1'b0, IM);
      chk("im_pc_we", 32'(pc_we), 0);
      chk("im_ifid_we", 32'(ifid_we), 1);
      chk("im_req_i", 32'(mem_req_i), 0);
      step(1'b0, IM);
      chk("ifill_req_i", 32'(mem_req_i), 1);
      step(1'b0, IM | DM);
      chk("ifill_dm_exmem_we", 32'(exmem_we), 0);
      chk("ifill_dm_memwb_bubble", 32'(memwb_bubble), 1);
      chk("ifill_dm_req_i", 32'(mem_req_i), 1);
      chk("ifill_dm_req_d", 32'(mem_req_d), 0);
      step(1'b0, IM | DM | MR);
      step(1'b0, DM);
      chk("i2d_req_d", 32'(mem_req_d), 1);
      chk("i2d_req_i", 32'(mem_req_i), 0);
      step(1'b0, DM | MR);
      step(1'b0, 6'b0);
      chk("i2d_done_pc_we", 32'(pc_we), 1);

      // Reset in the middle of a fill
      step(1'b0, DM);
      step(1'b0, DM);
      chk("abort_pre_req_d", 32'(mem_req_d), 1);
      step(1'b1, DM);
      chk("abort_req_d", 32'(mem_req_d), 0);
      step(1'b0, 6'b0);
      chk("abort_pc_we", 32'(pc_we), 1);
      chk("abort_cnt", 32'(stall_cycles), 0);

      // Halt, then leave it only by reset
      step(1'b0, HW);
      chk("hlt_pc_we", 32'(pc_we), 0);
      chk("hlt_halted_same", 32'(halted), 0);
      step(1'b0, 6'b0);
      chk("halted", 32'(halted), 1);
      chk("halted_idex_we", 32'(idex_we), 0);
      step(1'b0, HZ | DM | MR);
      chk("halted_req_d", 32'(mem_req_d), 0);
      chk("halted_cnt", 32'(stall_cycles), 1);
      step(1'b1, 6'b0);
      chk("halted_during_rst", 32'(halted), 1);
      step(1'b0, 6'b0);
      chk("halted_cleared", 32'(halted), 0);
      chk("post_halt_pc_we", 32'(pc_we), 1);

      // Counter saturation
      step(1'b1, 6'b0);
      repeat (20) step(1'b0, HZ);
      step(1'b0, 6'b0);
      chk("sat_cnt", 32'(stall_cycles), 15);
      chk("sat_pc_we", 32'(pc_we), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage pipeline.
- Combines the hazard-detect request (load-use and load-byte stalls), branch redirect, I/D cache misses and halt into per-stage write-enable, flush and bubble controls.
- Arbitrates the single main-memory fill port between instruction and data misses.
- Sits beside the forwarding unit and consumes its stall output.

## Interface
Parameters
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- hazard_stall  in  1  ID-stage stall request (load-use or load-byte dependency).
- branch_taken_ID  in  1  taken branch/jump resolved in ID.
- icache_miss  in  1  IF-stage fetch miss; held by the cache until its fill completes.
- dcache_miss  in  1  MEM-stage access miss; held by the cache until its fill completes.
- mem_ready  in  1  main memory: current fill complete; one-cycle pulse.
- halt_WB  in  1  HLT instruction is in WB.
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  load NOP into IF/ID; only meaningful with ifid_we=1.
- idex_bubble  out  1  load NOP into ID/EX.
- idex_we  out  1  ID/EX write enable.
- exmem_we  out  1  EX/MEM write enable.
- memwb_bubble  out  1  load NOP into MEM/WB.
- mem_req_d  out  1  data-side fill grant/request to main memory.
- mem_req_i  out  1  instruction-side fill grant/request to main memory.
- halted  out  1  pipeline frozen after HLT.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0 in RUN/DFILL/IFILL.

## Operation
- States: RUN, DFILL, IFILL, HALT. Registered state; outputs are Mealy, combinational from state and inputs.
- Reset: state=RUN, stall_cycles=0, halted=0.
  - While rst=1: all write enables 0, flush/bubble 0, mem_req_* 0.

RUN output priority, highest first:
1. halt_WB: all enables 0; next state HALT.
2. dcache_miss: pc_we=ifid_we=idex_we=exmem_we=0, memwb_bubble=1; next state DFILL. If icache_miss is also set, D is served first.
3. hazard_stall: pc_we=0, ifid_we=0, idex_bubble=1, idex_we=1, exmem_we=1. branch_taken_ID is ignored; the branch re-resolves next cycle.
4. icache_miss: pc_we=0, ifid_we=1, ifid_flush=1, idex_we=exmem_we=1; next state IFILL.
5. branch_taken_ID: all enables 1, ifid_flush=1.
6. Otherwise: all enables 1; flush/bubble 0.

Fill and halt states:
- DFILL: mem_req_d=1, mem_req_i=0; freeze outputs as in RUN case 2.
  - On mem_ready: next state IFILL if icache_miss=1, else RUN.
- IFILL: mem_req_i=1, mem_req_d=0; outputs as RUN case 4, except that if dcache_miss rises, stages EX and beyond also freeze (RUN case 2 outputs). Case 2 applies only while dcache_miss=1; the state stays IFILL and mem_req_d stays 0.
  - On mem_ready: next state DFILL if dcache_miss=1, else RUN.
- HALT: all enables 0, mem_req_* 0, halted=1. Left only by rst.
- mem_req_d and mem_req_i are never both 1. A grant holds constant until the cycle mem_ready=1 (inclusive).
- mem_ready outside DFILL/IFILL is ignored.
- stall_cycles: +1 on each cycle with pc_we=0 and state≠HALT and rst=0. Saturates at 2^CNT_W−1; no wrap.

## Timing
- Control outputs respond in the same cycle as their inputs. State changes take effect at the next edge.
- Load-use stall costs exactly one bubble per cycle hazard_stall is held.
- Branch penalty: 1 cycle (the flushed IF/ID slot).
- Fill latency equals memory latency. The first normal RUN cycle is the cycle after mem_ready.
- Reset asserted mid-fill aborts the fill: the next cycle is RUN, grants drop immediately.
- Reset asserted in HALT clears halted the next cycle.

## Test plan
- Load-use: hazard_stall=1 for one cycle with branch_taken_ID=1 → pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0. The next cycle (stall low, branch high) gives ifid_flush=1. stall_cycles=1.
- D miss: dcache_miss high at cycle 0, mem_ready pulse at cycle 5 → cycles 0–5 show pc_we=exmem_we=0, memwb_bubble=1; mem_req_d=1 on cycles 1–5; RUN at cycle 6; stall_cycles=6.
- Simultaneous misses: icache_miss=dcache_miss=1 → DFILL first (mem_req_d=1, mem_req_i=0). After mem_ready, IFILL (mem_req_i=1, ifid_flush=1). Grants are never both high.
- I miss with D miss arriving in IFILL → freeze of EX onward while the I-fill continues. After mem_ready, state DFILL, mem_req_d=1.
- halt_WB=1 → next cycle halted=1, all enables 0, stall_cycles frozen. rst=1 → halted=0, state RUN.
- Saturation, with CNT_W=4: hold hazard_stall for 20 cycles → stall_cycles stops at 15.
